// File: rtl/hms_alarm.sv
// Alarm stage: stores a settable alarm time, rings a gated buzzer tone on a time match.
// Setting and ring start/stop take effect one clk after the input; no backpressure.
module hms_alarm #(
  parameter int unsigned TONE_DIV = 50000,
  parameter int unsigned BEEP_DIV = 12500000,
  parameter int unsigned SEC_DIV  = 50000000,
  parameter int unsigned RING_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_alarm_en,
  input  logic       i_set_en,
  input  logic [1:0] i_pos,
  input  logic       i_inc,
  input  logic       i_stop,
  output logic [4:0] o_alarm_hour,
  output logic [5:0] o_alarm_min,
  output logic [5:0] o_alarm_sec,
  output logic       o_alarm_active,
  output logic       o_buzz
);

  localparam logic [31:0] TONE_LAST = 32'(TONE_DIV - 1);
  localparam logic [31:0] BEEP_LAST = 32'(BEEP_DIV - 1);
  localparam logic [31:0] SEC_LAST  = 32'(SEC_DIV - 1);
  localparam logic [31:0] RING_LAST = 32'(RING_SEC - 1);

  typedef enum logic {IDLE = 1'b0, RING = 1'b1} state_t;

  state_t      state;
  logic [31:0] tone_cnt;
  logic [31:0] gate_cnt;
  logic [31:0] cyc_cnt;
  logic [31:0] sec_cnt;
  logic        tone_q;
  logic        gate_q;
  logic        match;
  logic        match_d;
  logic        trigger;
  logic        timeout;

  assign match   = (i_hour == o_alarm_hour) && (i_min == o_alarm_min) && (i_sec == o_alarm_sec);
  // Rising edge of match only, so a held matching second rings once and setup edits never ring.
  assign trigger = match & ~match_d & i_alarm_en & ~i_set_en & ~i_stop;
  assign timeout = (cyc_cnt == SEC_LAST) && (sec_cnt == RING_LAST);

  // AND of registers only, so the buzzer line cannot glitch.
  assign o_buzz  = tone_q & gate_q & (state == RING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_alarm_hour <= '0;
      o_alarm_min  <= '0;
      o_alarm_sec  <= '0;
      match_d      <= 1'b0;
    end else begin
      match_d <= match;
      if (i_set_en && i_inc) begin
        case (i_pos)
          2'd0: o_alarm_sec  <= (o_alarm_sec  == 6'd59) ? 6'd0 : o_alarm_sec  + 6'd1;
          2'd1: o_alarm_min  <= (o_alarm_min  == 6'd59) ? 6'd0 : o_alarm_min  + 6'd1;
          2'd2: o_alarm_hour <= (o_alarm_hour == 5'd23) ? 5'd0 : o_alarm_hour + 5'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      o_alarm_active <= 1'b0;
      tone_cnt       <= '0;
      gate_cnt       <= '0;
      cyc_cnt        <= '0;
      sec_cnt        <= '0;
      tone_q         <= 1'b0;
      gate_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state          <= RING;
            o_alarm_active <= 1'b1;
            tone_cnt       <= '0;
            gate_cnt       <= '0;
            cyc_cnt        <= '0;
            sec_cnt        <= '0;
            tone_q         <= 1'b0;
            gate_q         <= 1'b1;
          end
        end
        RING: begin
          if (i_stop || !i_alarm_en || timeout) begin
            state          <= IDLE;
            o_alarm_active <= 1'b0;
            tone_cnt       <= '0;
            gate_cnt       <= '0;
            cyc_cnt        <= '0;
            sec_cnt        <= '0;
            tone_q         <= 1'b0;
            gate_q         <= 1'b0;
          end else begin
            if (tone_cnt == TONE_LAST) begin
              tone_cnt <= '0;
              tone_q   <= ~tone_q;
            end else begin
              tone_cnt <= tone_cnt + 32'd1;
            end
            if (gate_cnt == BEEP_LAST) begin
              gate_cnt <= '0;
              gate_q   <= ~gate_q;
            end else begin
              gate_cnt <= gate_cnt + 32'd1;
            end
            if (cyc_cnt == SEC_LAST) begin
              cyc_cnt <= '0;
              sec_cnt <= sec_cnt + 32'd1;
            end else begin
              cyc_cnt <= cyc_cnt + 32'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hms_alarm.sv
module tb_hms_alarm;

  localparam int TONE = 4;
  localparam int BEEP = 16;
  localparam int SDIV = 10;
  localparam int RSEC = 3;
  localparam int RING_LEN = RSEC * SDIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       en = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] pos = 2'd3;
  logic       inc = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] a_hour;
  logic [5:0] a_min;
  logic [5:0] a_sec;
  logic       active;
  logic       buzz;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: alarm fields as plain integers, ring as "cycles since entry".
  int ah, am, as_;
  bit m_prev, m_ring;
  int m_k;

  hms_alarm #(.TONE_DIV(TONE), .BEEP_DIV(BEEP), .SEC_DIV(SDIV), .RING_SEC(RSEC)) dut (
    .clk(clk), .rst_n(rst_n), .i_hour(hour), .i_min(min), .i_sec(sec),
    .i_alarm_en(en), .i_set_en(set_en), .i_pos(pos), .i_inc(inc), .i_stop(stop),
    .o_alarm_hour(a_hour), .o_alarm_min(a_min), .o_alarm_sec(a_sec),
    .o_alarm_active(active), .o_buzz(buzz)
  );

  always #5 clk = ~clk;

  function automatic bit exp_buzz();
    return m_ring && ((m_k / TONE) % 2 == 1) && ((m_k / BEEP) % 2 == 0);
  endfunction

  task automatic model_reset();
    ah = 0; am = 0; as_ = 0; m_prev = 0; m_ring = 0; m_k = 0;
  endtask

  task automatic model_step();
    bit match, trig;
    match = (int'(hour) == ah) && (int'(min) == am) && (int'(sec) == as_);
    trig  = match && !m_prev && en && !set_en && !stop;
    if (m_ring) begin
      m_k++;
      if (stop || !en || m_k == RING_LEN) m_ring = 0;
    end else if (trig) begin
      m_ring = 1;
      m_k = 0;
    end
    m_prev = match;
    if (set_en && inc) begin
      case (pos)
        2'd0: as_ = (as_ + 1) % 60;
        2'd1: am  = (am + 1) % 60;
        2'd2: ah  = (ah + 1) % 24;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic pulse_inc(input logic [1:0] p);
    pos = p; inc = 1'b1; tick(); inc = 1'b0; tick();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h); min = 6'(m); sec = 6'(s);
  endtask

  // Time moves off the alarm for a cycle then onto it; ring begins at the second edge.
  task automatic start_ring();
    set_time((ah + 1) % 24, am, as_);
    tick();
    set_time(ah, am, as_);
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_en = 1'b1;
    repeat (1 + $urandom_range(0, 4)) pulse_inc(2'd0);
    pulse_inc(2'd2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_hour !== 5'd0) begin n_err++; $display("FAIL reset_hour got=%0d want=0", a_hour); end
    n_cmp++; if (a_min !== 6'd0) begin n_err++; $display("FAIL reset_min got=%0d want=0", a_min); end
    n_cmp++; if (a_sec !== 6'd0) begin n_err++; $display("FAIL reset_sec got=%0d want=0", a_sec); end
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got=%b want=0", active); end
    n_cmp++; if (buzz !== 1'b0) begin n_err++; $display("FAIL reset_buzz got=%b want=0", buzz); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) pulse_inc(2'd2);
    n_cmp++; if (a_hour !== 5'd1) begin n_err++; $display("FAIL hour_wrap got=%0d want=1", a_hour); end
    repeat (60) pulse_inc(2'd1);
    n_cmp++; if (a_min !== 6'd0) begin n_err++; $display("FAIL min_wrap got=%0d want=0", a_min); end
    pulse_inc(2'd3);
    n_cmp++;
    if (a_hour !== 5'd1 || a_min !== 6'd0 || a_sec !== 6'd0) begin
      n_err++; $display("FAIL pos3_nochange got=%0d:%0d:%0d want=1:0:0", a_hour, a_min, a_sec);
    end
    set_en = 1'b0;
    pulse_inc(2'd0);
    n_cmp++; if (a_sec !== 6'd0) begin n_err++; $display("FAIL inc_without_set got=%0d want=0", a_sec); end
  endtask

  task automatic test_trigger_timeout();
    int rise_i, fall_i, buzz_i, rises, buzz_hi;
    logic prev_act;
    set_en = 1'b1;
    repeat (2) pulse_inc(2'd1);
    repeat (3) pulse_inc(2'd0);
    set_en = 1'b0;
    en = 1'b1;
    set_time($urandom_range(2, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    tick(); tick();
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL pre_match_active got=%b want=0", active); end
    set_time(1, 2, 3);
    rise_i = -1; fall_i = -1; buzz_i = -1; rises = 0; buzz_hi = 0; prev_act = active;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++; if (active !== m_ring) begin n_err++; $display("FAIL trig_active i=%0d got=%b want=%b", i, active, m_ring); end
      n_cmp++; if (buzz !== exp_buzz()) begin n_err++; $display("FAIL trig_buzz i=%0d got=%b want=%b", i, buzz, exp_buzz()); end
      if (active === 1'b1 && prev_act !== 1'b1) begin rises++; if (rise_i < 0) rise_i = i; end
      if (active !== 1'b1 && prev_act === 1'b1 && fall_i < 0) fall_i = i;
      if (buzz === 1'b1) begin buzz_hi++; if (buzz_i < 0) buzz_i = i; end
      prev_act = active;
    end
    n_cmp++; if (rise_i !== 0) begin n_err++; $display("FAIL trig_latency got=%0d want=0", rise_i); end
    n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL trig_count got=%0d want=1", rises); end
    n_cmp++; if (buzz_i - rise_i !== TONE) begin n_err++; $display("FAIL first_buzz got=%0d want=%0d", buzz_i - rise_i, TONE); end
    n_cmp++; if (buzz_hi !== 8) begin n_err++; $display("FAIL buzz_high_cycles got=%0d want=8", buzz_hi); end
    n_cmp++; if (fall_i - rise_i !== RING_LEN) begin n_err++; $display("FAIL timeout_len got=%0d want=%0d", fall_i - rise_i, RING_LEN); end
  endtask

  task automatic test_stop();
    int n;
    start_ring();
    repeat (7) tick();
    n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL stop_pre_active got=%b want=1", active); end
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (active !== 1'b0 || buzz !== 1'b0) begin n_err++; $display("FAIL stop_idle got=%b%b want=00", active, buzz); end
    set_time((ah + 1) % 24, am, as_);
    tick();
    set_time(ah, am, as_);
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL stop_on_match i=%0d got=%b want=0", i, active); end
    end
    start_ring();
    n = 0;
    repeat (10) begin tick(); n++; end
    set_time((ah + 1) % 24, am, as_);
    tick(); n++;
    set_time(ah, am, as_);
    tick(); n++;
    while (active === 1'b1 && n < 40) begin
      tick(); n++;
      n_cmp++; if (buzz !== exp_buzz()) begin n_err++; $display("FAIL retrig_buzz n=%0d got=%b want=%b", n, buzz, exp_buzz()); end
    end
    n_cmp++; if (n !== RING_LEN) begin n_err++; $display("FAIL retrig_end got=%0d want=%0d", n, RING_LEN); end
  endtask

  task automatic test_disarm_setup();
    start_ring();
    repeat (5) tick();
    en = 1'b0; tick();
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL disarm got=%b want=0", active); end
    en = 1'b1;
    repeat (3) tick();
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rearm_no_ring got=%b want=0", active); end
    set_time(ah, am, (as_ + 1) % 60);
    set_en = 1'b1;
    tick();
    pulse_inc(2'd0);
    repeat (3) tick();
    set_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL setup_suppress i=%0d got=%b want=0", i, active); end
    end
    n_cmp++; if (a_sec !== sec) begin n_err++; $display("FAIL setup_sec got=%0d want=%0d", a_sec, sec); end
  endtask

  task automatic test_reset_midring();
    start_ring();
    repeat (12) tick();
    n_cmp++; if (active !== 1'b1 || buzz !== 1'b1) begin n_err++; $display("FAIL midring_pre got=%b%b want=11", active, buzz); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (active !== 1'b0 || buzz !== 1'b0) begin n_err++; $display("FAIL midring_reset got=%b%b want=00", active, buzz); end
    n_cmp++;
    if (a_hour !== 5'd0 || a_min !== 6'd0 || a_sec !== 6'd0) begin
      n_err++; $display("FAIL midring_time got=%0d:%0d:%0d want=0:0:0", a_hour, a_min, a_sec);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r == 5 || r == 6) set_time(ah, am, as_);
      else if (r == 7) set_time(ah, am, (as_ + 1) % 60);
      else if (r == 8) set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) set_en = ~set_en;
      stop = ($urandom_range(0, 29) == 0);
      inc  = ($urandom_range(0, 7) == 0);
      pos  = 2'($urandom_range(0, 3));
      tick();
      n_cmp++; if (active !== m_ring) begin n_err++; $display("FAIL rnd_active i=%0d got=%b want=%b", i, active, m_ring); end
      n_cmp++; if (buzz !== exp_buzz()) begin n_err++; $display("FAIL rnd_buzz i=%0d got=%b want=%b", i, buzz, exp_buzz()); end
      n_cmp++;
      if (int'(a_hour) != ah || int'(a_min) != am || int'(a_sec) != as_) begin
        n_err++; $display("FAIL rnd_time i=%0d got=%0d:%0d:%0d want=%0d:%0d:%0d", i, a_hour, a_min, a_sec, ah, am, as_);
      end
    end
    stop = 1'b0; inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger_timeout();
    test_stop();
    test_disarm_setup();
    test_reset_midring();
    en = 1'b1;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hms_alarm.md
Name: hms_alarm

Overview:
Alarm stage that sits downstream of the hour/minute/second counters and alongside the display path. It holds a programmable alarm time (hour:min:sec), set through single-cycle increment pulses from the switch controller. It compares the alarm time against the running time and, on a match, drives a gated buzzer tone until the user stops it or a ring timeout expires. The stored alarm time is exported for display during alarm setup.

Parameters:
TONE_DIV, 50000, clk cycles per buzzer half-period (500 Hz tone at 50 MHz).
BEEP_DIV, 12500000, clk cycles per on/off gate half-period (0.25 s).
SEC_DIV, 50000000, clk cycles per ring-timer second.
RING_SEC, 30, ring duration in seconds before auto-stop; range 1..63.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
i_hour  input  5  current hour, 0..23
i_min  input  6  current minute, 0..59
i_sec  input  6  current second, 0..59
i_alarm_en  input  1  level; 1 = alarm armed
i_set_en  input  1  level; 1 = alarm-setup mode
i_pos  input  2  field select: 0 = sec, 1 = min, 2 = hour, 3 = none
i_inc  input  1  single-cycle pulse; increments the selected field
i_stop  input  1  single-cycle pulse; silences a ringing alarm
o_alarm_hour  output  5  stored alarm hour
o_alarm_min  output  6  stored alarm minute
o_alarm_sec  output  6  stored alarm second
o_alarm_active  output  1  1 while in RING
o_buzz  output  1  buzzer drive

Behaviour:
- Clock and reset: single clock domain on clk, rising edge. rst_n is asynchronous, active-low; all registers clear on assertion.
- Reset values: alarm time 00:00:00; state IDLE; o_alarm_active = 0; o_buzz = 0; all counters = 0; match_d = 0.
- Alarm time setting:
  - The field is updated on the cycle after i_set_en = 1 and i_inc = 1.
  - i_pos selects sec (wrap 59 -> 0), min (wrap 59 -> 0) or hour (wrap 23 -> 0).
  - i_pos = 3: no change.
  - i_inc while i_set_en = 0: ignored.
  - Setting is allowed in either state and does not affect an ongoing ring.
- Match detection:
  - match = (i_hour, i_min, i_sec) equal to the stored alarm time.
  - match_d is match registered each cycle.
  - trigger = match & ~match_d & i_alarm_en & ~i_set_en & ~i_stop.
  - Edge detection gives at most one trigger per matching second. Editing the alarm time into a match during setup does not trigger.
- State machine:
  - IDLE -> RING on trigger. o_alarm_active = 1 from the next cycle.
  - RING -> IDLE on i_stop = 1, on i_alarm_en = 0, or on timeout. o_alarm_active = 0 and o_buzz = 0 from the next cycle.
  - Priority in RING: i_stop = i_alarm_en low > timeout. A trigger while in RING is ignored; the ring timer does not restart.
  - i_stop in IDLE: no effect, but it suppresses a trigger in the same cycle.
- Tone and gate:
  - On entry to RING: tone counter = 0, tone_q = 0, gate counter = 0, gate_q = 1.
  - In RING, the tone counter counts 0..TONE_DIV-1; tone_q toggles at the wrap.
  - In RING, the gate counter counts 0..BEEP_DIV-1; gate_q toggles at the wrap.
  - o_buzz = tone_q & gate_q & (state == RING), decoded from registers only (glitch-free). First high is TONE_DIV cycles after RING entry.
  - In IDLE the counters hold at 0.
- Ring timer:
  - The cycle counter counts 0..SEC_DIV-1 in RING; each wrap increments the second counter.
  - Timeout when the second counter reaches RING_SEC, i.e. RING lasts RING_SEC*SEC_DIV cycles after entry.
  - Both counters clear on entry to RING.
- Reset mid-ring: immediate return to IDLE with o_buzz = 0; the alarm time is lost (00:00:00).
- Widths: counters are 32-bit; comparisons are unsigned.

Test Plan:
Parameters for the bench: TONE_DIV = 4, BEEP_DIV = 16, SEC_DIV = 10, RING_SEC = 3.
1. Reset and setting: assert rst_n = 0 mid-run -> all outputs 0. Then set_en = 1, pos = 2, 25 inc pulses -> o_alarm_hour = 1; pos = 1, 60 pulses -> o_alarm_min = 0; pos = 3, pulse -> no change.
2. Trigger: alarm 01:02:03, en = 1. Drive time 01:02:03 and hold 50 cycles -> o_alarm_active rises 1 cycle after time change, exactly one trigger. o_buzz is first high 4 cycles after entry, tone period 8, gated off for cycles 16..31.
3. Timeout: after scenario 2 with no stop -> o_alarm_active falls exactly 30 cycles after entry and o_buzz = 0. Time still matching -> no retrigger.
4. Stop and simultaneous events: stop pulse at ring cycle 7 -> IDLE next cycle. Stop on the same cycle as the match edge -> no ring. Trigger again while ringing -> timer not restarted (ends at cycle 30).
5. Disarm and setup suppression: en dropped mid-ring -> IDLE next cycle. set_en = 1 while incrementing the alarm sec onto the current time -> no trigger.
6. Reset mid-ring at cycle 12 -> o_buzz = 0, o_alarm_active = 0 immediately (asynchronous), alarm time 00:00:00.
